// File: rtl/dqce_gate_ctrl_pkg.sv
// Shared types and helpers for the DQCE clock-gate sequencer.
// Optional statistics are enabled with DQCE_GATE_CTRL_STATS_EN.
package dqce_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] ON_CYCLES_MAX  = 32'hFFFF_FFFF;
  localparam logic [15:0] WAKE_COUNT_MAX = 16'hFFFF;

  // Width of a counter able to hold max(wake_cyc, idle_cyc); never below 1 bit.
  function automatic int cnt_width(input int wake_cyc, input int idle_cyc);
    int m;
    m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
    if (m < 1) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dqce_gate_timer.sv
// Loadable down-counter shared by the wake settle and idle hold-off phases.
// Decrements only while nonzero, so it never wraps.
module dqce_gate_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_value,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/dqce_gate_ctrl.sv
// Clock-enable sequencer for a Gowin DQCE gate: wake settle, shared req/ack, idle hold-off.
// Define DQCE_GATE_CTRL_STATS_EN to add the on_cycles / wake_count outputs.
module dqce_gate_ctrl
  import dqce_gate_ctrl_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            force_on,
  output logic [NREQ-1:0] ack,
  output logic            gate_ce,
  output logic            gate_busy
`ifdef DQCE_GATE_CTRL_STATS_EN
  ,
  output logic [31:0]     on_cycles,
  output logic [15:0]     wake_count
`endif
);

  localparam int CW = cnt_width(WAKE_CYC, IDLE_CYC);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'((IDLE_CYC == 0) ? 0 : IDLE_CYC - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic            w_any;
  logic            w_tmr_load;
  logic [CW-1:0]   w_tmr_load_val;
  logic            w_tmr_dec;
  logic [CW-1:0]   w_tmr_value;
  logic            w_tmr_zero;
  logic [NREQ-1:0] w_ack_next;
  logic [NREQ-1:0] r_ack;
  logic            r_gate_ce;
  logic            r_gate_busy;

  assign w_any = (|req) | force_on;

  dqce_gate_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_value    (w_tmr_value),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_next_state   = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = WAKE_LOAD;
    w_tmr_dec      = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_any) begin
          w_next_state   = ST_WAKE;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = WAKE_LOAD;
        end
      end
      // Wake always completes; a dropped request is handled from ON.
      ST_WAKE: begin
        if (w_tmr_zero) w_next_state = ST_ON;
        else            w_tmr_dec    = (w_tmr_value != '0);
      end
      ST_ON: begin
        if (!w_any) begin
          if (IDLE_CYC == 0) begin
            w_next_state = ST_OFF;
          end else begin
            w_next_state   = ST_HOLD;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = IDLE_LOAD;
          end
        end
      end
      // A new request wins over an expiring hold-off.
      ST_HOLD: begin
        if (w_any)           w_next_state = ST_ON;
        else if (w_tmr_zero) w_next_state = ST_OFF;
        else                 w_tmr_dec    = (w_tmr_value != '0);
      end
      default: w_next_state = ST_OFF;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ack
      assign w_ack_next[gi] = req[gi] & (w_next_state == ST_ON);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_OFF;
      r_ack       <= '0;
      r_gate_ce   <= 1'b0;
      r_gate_busy <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ack       <= w_ack_next;
      r_gate_ce   <= (w_next_state != ST_OFF);
      r_gate_busy <= (w_next_state == ST_WAKE) || (w_next_state == ST_HOLD);
    end
  end

  assign ack       = r_ack;
  assign gate_ce   = r_gate_ce;
  assign gate_busy = r_gate_busy;

`ifdef DQCE_GATE_CTRL_STATS_EN
  logic [31:0] r_on_cycles;
  logic [15:0] r_wake_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_on_cycles  <= '0;
      r_wake_count <= '0;
    end else begin
      if (r_gate_ce && (r_on_cycles != ON_CYCLES_MAX))
        r_on_cycles <= r_on_cycles + 32'd1;
      if ((r_state == ST_OFF) && (w_next_state == ST_WAKE) &&
          (r_wake_count != WAKE_COUNT_MAX))
        r_wake_count <= r_wake_count + 16'd1;
    end
  end

  assign on_cycles  = r_on_cycles;
  assign wake_count = r_wake_count;
`endif

endmodule
